// File: rtl/pc_predict_ras.sv
// Y86-64 fetch next-PC unit: holds the fetch PC, predicts jumps taken, calls to valC,
// and returns from a circular return-address stack that overwrites its oldest entry when full.
module pc_predict_ras #(
  parameter int                 ADDR_W    = 64,
  parameter int                 RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_valid_i,
  input  logic [3:0]                   icode_i,
  input  logic [ADDR_W-1:0]            valC_i,
  input  logic [ADDR_W-1:0]            valP_i,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic                         pc_valid_o,
  output logic                         halted_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_overflow_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [PW-1:0]     tp_reg, tp_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              push, pop;
  logic [PW-1:0]     push_ptr;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_top;

  assign push_ptr = tp_reg + PW'(1);
  assign ras_top  = ras_mem[tp_reg];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect_i) begin
      // No checkpoints: the RAS keeps whatever wrong-path pushes/pops did.
      pc_next    = redirect_pc_i;
      state_next = S_RUN;
    end else if (!stall_i && state_reg == S_RUN && instr_valid_i) begin
      case (icode_i)
        IHALT: state_next = S_HALTED;
        IJXX:  pc_next = valC_i;
        ICALL: begin
          pc_next = valC_i;
          push    = 1'b1;
        end
        IRET: begin
          if (count_reg != '0) begin
            pc_next = ras_top;
            pop     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
        default: pc_next = valP_i;
      endcase
    end
  end

  always_comb begin
    tp_next    = tp_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (push) begin
      tp_next = push_ptr;
      if (count_reg == CW'(RAS_DEPTH)) ovf_next = 1'b1;
      else                             count_next = count_reg + CW'(1);
    end else if (pop) begin
      tp_next    = tp_reg - PW'(1);
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_RUN;
      pc_reg    <= RESET_PC;
      tp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      tp_reg    <= tp_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Stack storage carries no reset; its contents are meaningless until pushed.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) ras_mem[push_ptr] <= valP_i;
  end

  assign pc_o           = pc_reg;
  assign pc_valid_o     = (state_reg == S_RUN);
  assign halted_o       = (state_reg == S_HALTED);
  assign ras_count_o    = count_reg;
  assign ras_overflow_o = ovf_reg;

endmodule
